mtsp_local_memory_bank: RTL and testbench

Responder side of the `i_local_memory_control` interface: a single-port 256-bit local memory bank that serves the stream-side master (the queue-to-memory transfer engine) and a core-side port.
- Arbitrates one access per cycle, with core priority and a starvation guard for the stream port.
- Drives `ready` backpressure and returns reads through a fixed-latency pipeline as one-cycle `valid` pulses.
- Sits inside each MTSP processor tile, directly behind the InterBus master.

---
 rtl/mtsp_local_memory_pkg.sv | 27 ++
 rtl/i_local_memory_control.sv | 30 +++
 rtl/mtsp_local_memory_readpipe.sv | 103 ++++++++++
 rtl/mtsp_local_memory_bank.sv | 133 +++++++++++++
 tb/tb_mtsp_local_memory_bank.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtsp_local_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_local_memory_pkg
// Purpose  : Shared types and parameter bounds for the MTSP local memory bank.
//            Holds the read-port tag enum, the data word width and the legal
//            ranges of READ_LATENCY and STARVE_LIMIT.
// Revision : 1.0 - initial release
// ============================================================================
package mtsp_local_memory_pkg;

  // One local-memory word is eight 32-bit dwords.
  localparam int DWORDX8_W = 256;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;

  localparam int STARVE_LIMIT_MIN = 1;
  localparam int STARVE_LIMIT_MAX = 15;

  // Identifies which requester a read in flight belongs to.
  typedef enum logic {
    PORT_STREAM = 1'b0,
    PORT_CORE   = 1'b1
  } port_e;

endpackage
`default_nettype wire

// File: rtl/i_local_memory_control.sv
`default_nettype none
// ============================================================================
// Module   : i_local_memory_control
// Purpose  : Request/response bundle between the queue-to-memory transfer
//            engine (master, modport m) and the local memory bank (slave,
//            modport s).
// Signals  : en/we/addr/wdata  master -> bank request
//            ready             bank -> master request accepted this cycle
//            valid/rdata       bank -> master read return (1-cycle pulse)
// Revision : 1.0 - initial release
// ============================================================================
interface i_local_memory_control
  import mtsp_local_memory_pkg::*;
#(
  parameter int INDEX_WIDTH = 10
) ();

  logic                   en;
  logic                   we;
  logic [INDEX_WIDTH-1:0] addr;
  logic [DWORDX8_W-1:0]   wdata;
  logic                   ready;
  logic                   valid;
  logic [DWORDX8_W-1:0]   rdata;

  modport s (input en, we, addr, wdata, output ready, valid, rdata);
  modport m (output en, we, addr, wdata, input ready, valid, rdata);

endinterface
`default_nettype wire

// File: rtl/mtsp_local_memory_readpipe.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_local_memory_readpipe
// Purpose  : Fixed-latency return path for accepted reads. Delays
//            {valid, tag, data} so that a read accepted at cycle T appears on
//            the owning port's registered outputs at T+LATENCY, then demuxes
//            the pulse by tag and captures the data (held between pulses).
// Ports    : clk_i, rst_ni            clock, async active-low reset
//            rd_valid_i/tag_i/data_i   read accepted this cycle + its data
//            strm_valid_o/rdata_o      stream-port return
//            core_valid_o/rdata_o      core-port return
//            in_flight_o               a read is inside the delay stages
// Revision : 1.0 - initial release
// ============================================================================
module mtsp_local_memory_readpipe
  import mtsp_local_memory_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int DATA_W  = DWORDX8_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_valid_i,
  input  port_e             rd_tag_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              strm_valid_o,
  output logic [DATA_W-1:0] strm_rdata_o,
  output logic              core_valid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              in_flight_o
);

  logic              w_tail_v;
  port_e             w_tail_tag;
  logic [DATA_W-1:0] w_tail_data;

  // The output registers are the last pipeline stage, so LATENCY-1 delay
  // stages sit in front of them.
  generate
    if (LATENCY == 1) begin : g_direct
      assign w_tail_v    = rd_valid_i;
      assign w_tail_tag  = rd_tag_i;
      assign w_tail_data = rd_data_i;
      assign in_flight_o = 1'b0;
    end else begin : g_stages
      logic [LATENCY-2:0] v_q;
      port_e              tag_q  [LATENCY-1];
      logic [DATA_W-1:0]  data_q [LATENCY-1];

      // Only the valid bits are reset; tag/data are don't-care when invalid.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= '0;
        end else begin
          v_q[0] <= rd_valid_i;
          for (int i = 1; i < LATENCY - 1; i++) begin
            v_q[i] <= v_q[i-1];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        tag_q[0]  <= rd_tag_i;
        data_q[0] <= rd_data_i;
        for (int i = 1; i < LATENCY - 1; i++) begin
          tag_q[i]  <= tag_q[i-1];
          data_q[i] <= data_q[i-1];
        end
      end

      assign w_tail_v    = v_q[LATENCY-2];
      assign w_tail_tag  = tag_q[LATENCY-2];
      assign w_tail_data = data_q[LATENCY-2];
      assign in_flight_o = |v_q;
    end
  endgenerate

  logic              strm_valid_q;
  logic              core_valid_q;
  logic [DATA_W-1:0] strm_rdata_q;
  logic [DATA_W-1:0] core_rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strm_valid_q <= 1'b0;
      core_valid_q <= 1'b0;
      strm_rdata_q <= '0;
      core_rdata_q <= '0;
    end else begin
      strm_valid_q <= w_tail_v && (w_tail_tag == PORT_STREAM);
      core_valid_q <= w_tail_v && (w_tail_tag == PORT_CORE);
      if (w_tail_v && (w_tail_tag == PORT_STREAM)) strm_rdata_q <= w_tail_data;
      if (w_tail_v && (w_tail_tag == PORT_CORE))   core_rdata_q <= w_tail_data;
    end
  end

  assign strm_valid_o = strm_valid_q;
  assign strm_rdata_o = strm_rdata_q;
  assign core_valid_o = core_valid_q;
  assign core_rdata_o = core_rdata_q;

endmodule
`default_nettype wire

// File: rtl/mtsp_local_memory_bank.sv
`default_nettype none
// ============================================================================
// Module   : mtsp_local_memory_bank
// Purpose  : Single-port 256-bit local memory bank shared by the stream-side
//            master and the core. One access per cycle, core has priority,
//            a saturating starvation counter forces a stream win after
//            STARVE_LIMIT consecutive denials. Reads return after a fixed
//            READ_LATENCY as one-cycle valid pulses.
// Ports    : CLK, nRST              clock, async active-low reset
//            local_memory (s)       stream-side request/response bundle
//            CORE_EN/WE/ADDR/WDATA  core request
//            CORE_READY             core request accepted this cycle
//            CORE_VALID/RDATA       core read return
//            BUSY                   request pending or read in flight
// Revision : 1.0 - initial release
// ============================================================================
module mtsp_local_memory_bank
  import mtsp_local_memory_pkg::*;
#(
  parameter int INDEX_WIDTH  = 10,
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   CLK,
  input  logic                   nRST,
  i_local_memory_control.s       local_memory,
  input  logic                   CORE_EN,
  input  logic                   CORE_WE,
  input  logic [INDEX_WIDTH-1:0] CORE_ADDR,
  input  logic [DWORDX8_W-1:0]   CORE_WDATA,
  output logic                   CORE_READY,
  output logic [DWORDX8_W-1:0]   CORE_RDATA,
  output logic                   CORE_VALID,
  output logic                   BUSY
);

  localparam int         DEPTH       = 1 << INDEX_WIDTH;
  localparam logic [3:0] STARVE_SAT  = 4'(STARVE_LIMIT);

  generate
    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_read_latency
      $error("mtsp_local_memory_bank: READ_LATENCY must be 1..3");
    end
    if (STARVE_LIMIT < STARVE_LIMIT_MIN || STARVE_LIMIT > STARVE_LIMIT_MAX) begin : g_bad_starve_limit
      $error("mtsp_local_memory_bank: STARVE_LIMIT must be 1..15");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Arbitration. Readies depend only on CORE_EN and the counter, never on
  // the stream enable, so the master may derive en from ready safely.
  // --------------------------------------------------------------------------
  logic [3:0] r_STARVE;
  logic [3:0] w_starve_d;
  logic       w_force;
  logic       w_core_acc;
  logic       w_strm_acc;

  assign w_force            = (r_STARVE == STARVE_SAT);
  assign CORE_READY         = CORE_EN & ~w_force;
  assign local_memory.ready = ~CORE_EN | w_force;
  assign w_core_acc         = CORE_EN & ~w_force;
  assign w_strm_acc         = local_memory.en & (~CORE_EN | w_force);

  // Counts stream denials; cannot pass STARVE_SAT because reaching it forces
  // the next stream request through, which clears it.
  always_comb begin
    w_starve_d = r_STARVE;
    if (w_strm_acc) begin
      w_starve_d = '0;
    end else if (local_memory.en && CORE_EN && !w_force) begin
      w_starve_d = r_STARVE + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_STARVE <= '0;
    else       r_STARVE <= w_starve_d;
  end

  // --------------------------------------------------------------------------
  // Winning request mux and storage array (contents are not reset).
  // --------------------------------------------------------------------------
  logic                   w_acc;
  logic                   w_we;
  logic [INDEX_WIDTH-1:0] w_idx;
  logic [DWORDX8_W-1:0]   w_wdata;
  port_e                  w_rd_tag;

  always_comb begin
    w_acc    = w_core_acc | w_strm_acc;
    w_we     = local_memory.we;
    w_idx    = local_memory.addr;
    w_wdata  = local_memory.wdata;
    w_rd_tag = PORT_STREAM;
    if (w_core_acc) begin
      w_we     = CORE_WE;
      w_idx    = CORE_ADDR;
      w_wdata  = CORE_WDATA;
      w_rd_tag = PORT_CORE;
    end
  end

  logic [DWORDX8_W-1:0] mem_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (w_acc && w_we) mem_q[w_idx] <= w_wdata;
  end

  // Array is sampled in the accept cycle so later writes cannot alter a read
  // that is already in flight.
  logic w_in_flight;

  mtsp_local_memory_readpipe #(
    .LATENCY (READ_LATENCY),
    .DATA_W  (DWORDX8_W)
  ) u_readpipe (
    .clk_i        (CLK),
    .rst_ni       (nRST),
    .rd_valid_i   (w_acc & ~w_we),
    .rd_tag_i     (w_rd_tag),
    .rd_data_i    (mem_q[w_idx]),
    .strm_valid_o (local_memory.valid),
    .strm_rdata_o (local_memory.rdata),
    .core_valid_o (CORE_VALID),
    .core_rdata_o (CORE_RDATA),
    .in_flight_o  (w_in_flight)
  );

  assign BUSY = local_memory.en | CORE_EN | w_in_flight;

endmodule
`default_nettype wire

// File: tb/tb_mtsp_local_memory_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mtsp_local_memory_bank
// Purpose  : Self-checking bench for mtsp_local_memory_bank: directed
//            scenarios with literal expectations plus randomized two-port
//            traffic compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mtsp_local_memory_bank;
  import mtsp_local_memory_pkg::*;

  localparam int IW    = 10;
  localparam int LAT   = 2;
  localparam int LIMIT = 4;

  logic                 CLK = 1'b0;
  logic                 nRST = 1'b0;
  logic                 CORE_EN, CORE_WE;
  logic [IW-1:0]        CORE_ADDR;
  logic [DWORDX8_W-1:0] CORE_WDATA, CORE_RDATA;
  logic                 CORE_READY, CORE_VALID, BUSY;

  i_local_memory_control #(.INDEX_WIDTH(IW)) lm ();

  mtsp_local_memory_bank #(
    .INDEX_WIDTH  (IW),
    .READ_LATENCY (LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .local_memory (lm),
    .CORE_EN      (CORE_EN),
    .CORE_WE      (CORE_WE),
    .CORE_ADDR    (CORE_ADDR),
    .CORE_WDATA   (CORE_WDATA),
    .CORE_READY   (CORE_READY),
    .CORE_RDATA   (CORE_RDATA),
    .CORE_VALID   (CORE_VALID),
    .BUSY         (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural model: memory array, count of stream denials, and a list of
  // outstanding reads each stamped with the cycle its pulse must appear.
  // --------------------------------------------------------------------------
  typedef struct {
    int            due;
    bit            core;
    logic [255:0]  data;
  } rd_t;

  logic [255:0] m_mem [1 << IW];
  rd_t          q [$];
  int           m_starve = 0;
  int           k = 0;
  logic [255:0] e_sdata = '0;
  logic [255:0] e_cdata = '0;
  bit           e_sv, e_cv;

  always @(negedge CLK) begin
    rd_t e;
    bit  frc, c_acc, s_acc;
    k++;
    e_sv = 1'b0;
    e_cv = 1'b0;
    if (!nRST) begin
      q.delete();
      m_starve = 0;
      e_sdata  = '0;
      e_cdata  = '0;
    end else begin
      while (q.size() > 0 && q[0].due <= k) begin
        e = q.pop_front();
        if (e.due == k) begin
          if (e.core) begin e_cv = 1'b1; e_cdata = e.data; end
          else        begin e_sv = 1'b1; e_sdata = e.data; end
        end
      end
    end
    frc = (m_starve == LIMIT);
    chk("m_stream_ready", 256'(lm.ready),    256'(!CORE_EN || frc));
    chk("m_core_ready",   256'(CORE_READY),  256'(CORE_EN && !frc));
    chk("m_stream_valid", 256'(lm.valid),    256'(e_sv));
    chk("m_core_valid",   256'(CORE_VALID),  256'(e_cv));
    chk("m_stream_rdata", lm.rdata,          e_sdata);
    chk("m_core_rdata",   CORE_RDATA,        e_cdata);
    chk("m_busy",         256'(BUSY),        256'(lm.en || CORE_EN || q.size() > 0));
    if (nRST) begin
      c_acc = CORE_EN && !frc;
      s_acc = lm.en && (!CORE_EN || frc);
      if (s_acc)                                    m_starve = 0;
      else if (lm.en && CORE_EN && m_starve < LIMIT) m_starve++;
      if (c_acc) begin
        if (CORE_WE) m_mem[CORE_ADDR] = CORE_WDATA;
        else         q.push_back('{k + LAT, 1'b1, m_mem[CORE_ADDR]});
      end
      if (s_acc) begin
        if (lm.we) m_mem[lm.addr] = lm.wdata;
        else       q.push_back('{k + LAT, 1'b0, m_mem[lm.addr]});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus (inputs change 1 time unit after the rising edge).
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    lm.en   = 1'b0;
    lm.we   = 1'b0;
    CORE_EN = 1'b0;
    CORE_WE = 1'b0;
  endtask

  task automatic s_write(input int a, input logic [255:0] d);
    lm.en    = 1'b1;
    lm.we    = 1'b1;
    lm.addr  = IW'(a);
    lm.wdata = d;
    tick();
    lm.en    = 1'b0;
  endtask

  task automatic s_read(input int a);
    lm.en   = 1'b1;
    lm.we   = 1'b0;
    lm.addr = IW'(a);
  endtask

  initial begin
    int           pc, first;
    bit           s_acc, c_acc;
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    idle();
    lm.addr = '0;  lm.wdata = '0;
    CORE_ADDR = '0; CORE_WDATA = '0;
    nRST = 1'b0;

    // Reset with nothing requested.
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    chk("rst_stream_ready", 256'(lm.ready),   256'(1));
    chk("rst_core_ready",   256'(CORE_READY), 256'(0));
    chk("rst_stream_valid", 256'(lm.valid),   256'(0));
    chk("rst_core_valid",   256'(CORE_VALID), 256'(0));
    chk("rst_stream_rdata", lm.rdata,         256'(0));
    chk("rst_core_rdata",   CORE_RDATA,       256'(0));
    chk("rst_busy",         256'(BUSY),       256'(0));
    tick();
    nRST = 1'b1;

    for (int a = 0; a < 32; a++) s_write(a, 256'(a));

    // Write then read back the next cycle.
    s_write(5, a5);
    s_read(5);
    tick();
    lm.en = 1'b0;
    chk("wr_rd_early", 256'(lm.valid), 256'(0));
    tick();
    chk("wr_rd_valid", 256'(lm.valid), 256'(1));
    chk("wr_rd_data",  lm.rdata,       a5);
    tick();
    chk("wr_rd_pulse_end", 256'(lm.valid), 256'(0));
    s_write(5, 256'(5));

    // Back-to-back burst of reads of addr 0..7 (data == addr).
    pc = 0;
    for (int c = 0; c < 12; c++) begin
      if (lm.valid) begin
        chk("burst_data",  lm.rdata,  256'(pc));
        chk("burst_cycle", 256'(c),   256'(2 + pc));
        pc++;
      end
      if (c < 8) s_read(c);
      else       lm.en = 1'b0;
      tick();
    end
    chk("burst_count", 256'(pc), 256'(8));

    // Both ports request continuously: stream waits LIMIT cycles then wins.
    s_read(1);
    CORE_EN = 1'b1; CORE_WE = 1'b0; CORE_ADDR = IW'(0);
    first = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK); #1;
      if (lm.ready && first < 0) begin
        first = n;
        chk("starve_core_denied", 256'(CORE_READY), 256'(0));
      end else if (first > 0 && n == first + 1) begin
        chk("starve_core_resumes", 256'(CORE_READY), 256'(1));
        chk("starve_stream_blocked", 256'(lm.ready), 256'(0));
      end
    end
    chk("starve_wait", 256'(first), 256'(LIMIT + 1));
    tick();
    idle();
    repeat (4) tick();

    // Core read addr 3 at T, stream read addr 4 at T+1.
    for (int c = 0; c < 7; c++) begin
      chk("mix_core_valid",   256'(CORE_VALID), 256'(c == 2));
      chk("mix_stream_valid", 256'(lm.valid),   256'(c == 3));
      if (c == 2) chk("mix_core_data",   CORE_RDATA, 256'(3));
      if (c == 3) chk("mix_stream_data", lm.rdata,   256'(4));
      idle();
      if (c == 0) begin CORE_EN = 1'b1; CORE_WE = 1'b0; CORE_ADDR = IW'(3); end
      if (c == 1) s_read(4);
      tick();
    end

    // Reset while a read is in flight.
    s_read(7);
    tick();
    idle();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("rstmid_stream_valid", 256'(lm.valid),   256'(0));
      chk("rstmid_core_valid",   256'(CORE_VALID), 256'(0));
      chk("rstmid_stream_rdata", lm.rdata,         256'(0));
      tick();
    end

    // Randomized traffic on both ports; stalled requests are held stable.
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      s_acc = lm.en && lm.ready;
      c_acc = CORE_EN && CORE_READY;
      @(posedge CLK); #1;
      if (!nRST) begin
        nRST = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        nRST = 1'b0;
        idle();
      end else begin
        if (!(lm.en && !s_acc)) begin
          lm.en    = ($urandom_range(0, 2) != 0);
          lm.we    = $urandom_range(0, 1) == 1;
          lm.addr  = IW'($urandom_range(0, 31));
          lm.wdata = rand256();
        end
        if (!(CORE_EN && !c_acc)) begin
          CORE_EN    = ($urandom_range(0, 2) != 0);
          CORE_WE    = $urandom_range(0, 1) == 1;
          CORE_ADDR  = IW'($urandom_range(0, 31));
          CORE_WDATA = rand256();
        end
      end
    end
    nRST = 1'b1;
    idle();
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
